// File: rtl/mem_arb_pkg.sv
// Shared types, func3 encodings and the access legality check for the data RAM arbiter.
package mem_arb_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned NUM_MASTERS = 2;

   typedef logic [0:0] master_id_t;

   // Flags misaligned, out-of-range or unsupported-width accesses; depth is in 32-bit words.
   function automatic logic access_err(input logic [31:0] addr,
                                       input logic [2:0]  func3,
                                       input int unsigned depth);
      logic        misaligned;
      logic        out_of_range;
      logic        bad_f3;
      logic [33:0] limit;
      limit        = 34'(depth) << 2;
      misaligned   = ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                     ((func3[1:0] == 2'b01) && addr[0]);
      out_of_range = ({2'b00, addr} >= limit);
      bad_f3       = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      return misaligned || out_of_range || bad_f3;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; last_gnt remembers the most recent winner.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt
);

   master_id_t last_gnt;

   always_comb begin
      gnt = '0;
      if (!reset) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_gnt <= 1'b1;
      else if (|gnt)
         last_gnt <= gnt[1];
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data RAM between the load/store unit (0) and debug/loader (1) with a one-cycle response.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_MASTERS-1:0]       m_req,
   input  logic [NUM_MASTERS-1:0]       m_we,
   input  logic [NUM_MASTERS-1:0][31:0] m_addr,
   input  logic [NUM_MASTERS-1:0][31:0] m_wData,
   input  logic [NUM_MASTERS-1:0][2:0]  m_func3,
   output logic [NUM_MASTERS-1:0]       m_gnt,
   output logic [NUM_MASTERS-1:0]       m_rvalid,
   output logic                         m_err,
   output logic [31:0]                  m_rData,
   output logic                         ram_we,
   output logic [31:0]                  ram_addr,
   output logic [31:0]                  ram_wData,
   output logic [2:0]                   ram_func3,
   input  logic [31:0]                  ram_rData
);

   master_id_t  sel;
   logic        granted;
   logic        req_err;

   logic        rsp_valid;
   master_id_t  rsp_id;
   logic        rsp_err;
   logic [31:0] rsp_data;

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .req   (m_req),
      .gnt   (m_gnt)
   );

   // With no grant sel stays 0, so the RAM sees master 0's payload.
   assign granted   = |m_gnt;
   assign sel       = master_id_t'(m_gnt[1]);
   assign ram_addr  = m_addr[sel];
   assign ram_wData = m_wData[sel];
   assign ram_func3 = m_func3[sel];
   assign req_err   = access_err(ram_addr, ram_func3, DEPTH_WORDS);
   assign ram_we    = granted & m_we[sel] & ~req_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= granted;
         rsp_id    <= sel;
         rsp_err   <= granted & req_err;
         rsp_data  <= (granted && !m_we[sel] && !req_err) ? ram_rData : '0;
      end
   end

   always_comb begin
      m_rvalid         = '0;
      m_rvalid[rsp_id] = rsp_valid;
   end

   assign m_err   = rsp_err;
   assign m_rData = rsp_data;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural func3-aware RAM attached.
module tb_data_mem_arbiter;
   import mem_arb_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        m_req;
   logic [1:0]        m_we;
   logic [1:0][31:0]  m_addr;
   logic [1:0][31:0]  m_wData;
   logic [1:0][2:0]   m_func3;
   logic [1:0]        m_gnt;
   logic [1:0]        m_rvalid;
   logic              m_err;
   logic [31:0]       m_rData;
   logic              ram_we;
   logic [31:0]       ram_addr;
   logic [31:0]       ram_wData;
   logic [2:0]        ram_func3;
   logic [31:0]       ram_rData;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:63];

   data_mem_arbiter #(.DEPTH_WORDS(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .m_req     (m_req),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wData   (m_wData),
      .m_func3   (m_func3),
      .m_gnt     (m_gnt),
      .m_rvalid  (m_rvalid),
      .m_err     (m_err),
      .m_rData   (m_rData),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wData (ram_wData),
      .ram_func3 (ram_func3),
      .ram_rData (ram_rData)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: sync write, combinational read with sign/zero extension.
   always @(posedge clk) begin
      if (ram_we && ram_addr < 32'd256) begin
         case (ram_func3[1:0])
            2'b00:   mem[ram_addr[7:2]][8*ram_addr[1:0] +: 8]  <= ram_wData[7:0];
            2'b01:   mem[ram_addr[7:2]][16*ram_addr[1] +: 16] <= ram_wData[15:0];
            default: mem[ram_addr[7:2]]                       <= ram_wData;
         endcase
      end
   end

   function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = (a < 32'd256) ? mem[a[7:2]] : 32'h0;
      b = w[8*a[1:0] +: 8];
      h = w[16*a[1] +: 16];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'h0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'h0, h};
         default: return w;
      endcase
   endfunction

   always_comb ram_rData = ram_read(ram_addr, ram_func3);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m_req   = '0;
      m_we    = '0;
      m_addr  = '0;
      m_wData = '0;
      m_func3 = '0;
   endtask

   task automatic drive(input int unsigned m, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3);
      m_req[m]   = 1'b1;
      m_we[m]    = we;
      m_addr[m]  = addr;
      m_wData[m] = data;
      m_func3[m] = f3;
   endtask

   // Single-master access: checks grant before the edge and the response after it.
   task automatic single(input string tag, input int unsigned m, input logic we,
                         input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                         input logic exp_we, input logic exp_err, input logic [31:0] exp_data);
      logic [1:0] g;
      g = (m == 0) ? 2'b01 : 2'b10;
      idle();
      drive(m, we, addr, data, f3);
      #1;
      check({tag, "_gnt"}, 32'(m_gnt), 32'(g));
      check({tag, "_ram_we"}, 32'(ram_we), 32'(exp_we));
      tick();
      check({tag, "_rvalid"}, 32'(m_rvalid), 32'(g));
      check({tag, "_err"}, 32'(m_err), 32'(exp_err));
      check({tag, "_rdata"}, m_rData, exp_data);
   endtask

   initial begin
      logic [1:0]  exp_g  [4];
      logic [31:0] exp_d  [4];
      exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
      exp_d = '{32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};

      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      drive(0, 1'b1, 32'h0, 32'h1111_1111, F3_W);
      drive(1, 1'b1, 32'h4, 32'h2222_2222, F3_W);
      #1;
      check("rst_gnt", 32'(m_gnt), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      idle();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_rvalid", 32'(m_rvalid), 32'h0);
      check("rst_err", 32'(m_err), 32'h0);
      check("rst_rdata", m_rData, 32'h0);

      single("sw10", 1, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b1, 1'b0, 32'h0);
      single("sw00", 1, 1'b1, 32'h00, 32'h12345678, F3_W, 1'b1, 1'b0, 32'h0);
      single("swfc", 1, 1'b1, 32'hFC, 32'h0BADCAFE, F3_W, 1'b1, 1'b0, 32'h0);
      single("lw10", 0, 1'b0, 32'h10, 32'h0, F3_W, 1'b0, 1'b0, 32'hDEADBEEF);

      // Pointer now at master 0, so contention starts with master 1.
      idle();
      drive(0, 1'b0, 32'h10, 32'h0, F3_W);
      drive(1, 1'b0, 32'h00, 32'h0, F3_W);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("cont%0d_gnt", i), 32'(m_gnt), 32'(exp_g[i]));
         tick();
         check($sformatf("cont%0d_rvalid", i), 32'(m_rvalid), 32'(exp_g[i]));
         check($sformatf("cont%0d_rdata", i), m_rData, exp_d[i]);
      end

      single("sb21", 1, 1'b1, 32'h21, 32'h123456A5, F3_B, 1'b1, 1'b0, 32'h0);
      single("lbu21", 0, 1'b0, 32'h21, 32'h0, F3_BU, 1'b0, 1'b0, 32'h000000A5);
      single("lb21", 0, 1'b0, 32'h21, 32'h0, F3_B, 1'b0, 1'b0, 32'hFFFFFFA5);
      single("lwfc", 0, 1'b0, 32'hFC, 32'h0, F3_W, 1'b0, 1'b0, 32'h0BADCAFE);

      single("sw102", 0, 1'b1, 32'h102, 32'hFFFFFFFF, F3_W, 1'b0, 1'b1, 32'h0);
      single("lw100", 0, 1'b0, 32'h100, 32'h0, F3_W, 1'b0, 1'b1, 32'h0);
      single("lw02mis", 0, 1'b0, 32'h02, 32'h0, F3_W, 1'b0, 1'b1, 32'h0);
      single("sh21mis", 0, 1'b1, 32'h21, 32'hFFFF, F3_H, 1'b0, 1'b1, 32'h0);
      single("f3_011", 0, 1'b1, 32'h00, 32'hFFFFFFFF, 3'b011, 1'b0, 1'b1, 32'h0);
      single("lw00", 0, 1'b0, 32'h00, 32'h0, F3_W, 1'b0, 1'b0, 32'h12345678);

      // Grant a read, then reset in the response cycle; the pointer is at master 0 here.
      single("pre_rst", 0, 1'b0, 32'h10, 32'h0, F3_W, 1'b0, 1'b0, 32'hDEADBEEF);
      idle();
      drive(0, 1'b0, 32'h10, 32'h0, F3_W);
      #1;
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_rvalid", 32'(m_rvalid), 32'h0);
      check("mid_rst_rdata", m_rData, 32'h0);
      check("mid_rst_err", 32'(m_err), 32'h0);
      idle();
      drive(0, 1'b0, 32'h00, 32'h0, F3_W);
      drive(1, 1'b1, 32'h00, 32'hCAFEF00D, F3_W);
      #1;
      check("mid_rst_gnt", 32'(m_gnt), 32'h0);
      check("mid_rst_ram_we", 32'(ram_we), 32'h0);
      tick();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_gnt0", 32'(m_gnt), 32'h1);
      tick();
      check("post_rst_rv0", 32'(m_rvalid), 32'h1);
      check("post_rst_rd0", m_rData, 32'h12345678);
      check("post_rst_gnt1", 32'(m_gnt), 32'h2);
      check("post_rst_we1", 32'(ram_we), 32'h1);
      tick();
      check("post_rst_rv1", 32'(m_rvalid), 32'h2);
      check("post_rst_gnt2", 32'(m_gnt), 32'h1);
      tick();
      check("raw_rdata", m_rData, 32'hCAFEF00D);
      idle();
      tick();
      tick();
      check("idle_rvalid", 32'(m_rvalid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
